// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART TX line between NUM_REQ byte sources.
// Frames are start + DATA_W bits LSB-first + STOP_BITS stop bits, paced by baud_tick.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         baud_tick,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DATA_W + STOP_BITS);

  typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, STOP} state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     sel;
  logic [ID_W-1:0]     cand;
  logic                found;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                tx_d;
  logic                last_data;
  logic                last_stop;

  assign last_data = (bit_cnt == CNT_W'(DATA_W - 1));
  assign last_stop = (bit_cnt == CNT_W'(STOP_BITS - 1));
  assign busy      = (state != IDLE);

  // First valid requester searching upward from ptr, wrapping at NUM_REQ
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found) req_ready[sel] = 1'b1;
  end

  always_comb begin
    state_d = state;
    tx_d    = 1'b1;
    case (state)
      IDLE:  if (found) state_d = ALIGN;
      ALIGN: if (baud_tick) state_d = START;
      START: begin
        tx_d = 1'b0;
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        tx_d = shreg[0];
        if (baud_tick && last_data) state_d = STOP;
      end
      STOP:  if (baud_tick && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the current state, so it trails each transition by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      tx    <= tx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          shreg    <= req_data[sel*DATA_W +: DATA_W];
          grant_id <= sel;
          ptr      <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        end
        START: if (baud_tick) bit_cnt <= '0;
        DATA: if (baud_tick) begin
          shreg   <= shreg >> 1;
          bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
        end
        STOP: if (baud_tick) bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (STOP_BITS=1 and STOP_BITS=2 builds).
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        baud_tick;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        tx, busy;
  logic [1:0]  grant_id;
  logic [3:0]  req_valid2, req_ready2;
  logic [31:0] req_data2;
  logic        tx2, busy2;
  logic [1:0]  grant_id2;

  int   n_cmp = 0;
  int   n_err = 0;
  int   tick_period = 16;
  int   tick_cnt = 0;
  logic glitch;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
    .tx(tx2), .busy(busy2), .grant_id(grant_id2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and drive baud_tick for the following rising edge
  task automatic cyc();
    @(negedge clk);
    tick_cnt++;
    baud_tick = (tick_period <= 1) || (tick_cnt % tick_period == 0);
  endtask

  // Return once a tick is pending for the next rising edge; flags any tx change meanwhile
  task automatic wait_tick();
    logic t0;
    int   n;
    t0 = tx;
    n  = 0;
    while (baud_tick !== 1'b1 && n < 200) begin
      cyc();
      n++;
      if (tx !== t0) glitch = 1'b1;
    end
    if (baud_tick !== 1'b1) begin
      n_cmp++;
      n_err++;
      $error("FAIL tick_wait: observed no tick expected tick within 200 cycles");
    end
  endtask

  task automatic send_check(input int id, input logic [7:0] data, input string tag, input bit drop);
    logic [7:0] rx;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1 << id);
    cyc();
    if (drop) req_valid[id] = 1'b0;
    chk({tag, "_grant"}, 32'(grant_id), 32'(id));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready_pulse"}, 32'(req_ready), 32'd0);
    glitch = 1'b0;
    wait_tick(); cyc(); cyc();
    chk({tag, "_start"}, 32'(tx), 32'd0);
    for (int b = 0; b < 8; b++) begin
      wait_tick(); cyc(); cyc();
      rx[b] = tx;
    end
    chk({tag, "_byte"}, 32'(rx), 32'(data));
    wait_tick(); cyc(); cyc();
    chk({tag, "_stop"}, 32'(tx), 32'd1);
    chk({tag, "_stop_busy"}, 32'(busy), 32'd1);
    wait_tick(); cyc();
    chk({tag, "_done"}, 32'(busy), 32'd0);
    chk({tag, "_glitch"}, 32'(glitch), 32'd0);
    chk({tag, "_grant_hold"}, 32'(grant_id), 32'(id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  rx;
    logic [10:0] exp_tx;
    rst_n = 1'b0; baud_tick = 1'b0;
    req_valid = 4'b1111; req_data = '0;
    req_valid2 = 4'b1111; req_data2 = '0;
    tick_period = 16;
    repeat (3) cyc();
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tx2", 32'(tx2), 32'd1);
    chk("rst_ready2", 32'(req_ready2), 32'd0);
    req_valid = '0; req_valid2 = '0;
    cyc(); rst_n = 1'b1;
    cyc(); cyc();
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single send from requester 1, 16-cycle bit period
    req_data = 32'h44_33_A5_11;
    req_valid = 4'b0010;
    send_check(1, 8'hA5, "single", 1'b1);
    cyc();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_grant", 32'(grant_id), 32'd1);

    // Round-robin from pointer 0 with all four valid
    rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
    tick_period = 4;
    req_data = 32'h13_12_11_10;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) send_check(i % 4, 8'h10 + 8'(i % 4), "rr", 1'b0);
    req_valid = '0;
    cyc();
    chk("withdraw_busy", 32'(busy), 32'd0);

    // Pointer skip and wrap: pointer 1 -> grant 2 -> pointer 3 -> grant 1 -> pointer 2
    req_data = 32'h00_3C_00_00;
    req_valid = 4'b0100;
    send_check(2, 8'h3C, "skip2", 1'b1);
    req_data = 32'h00_00_C3_00;
    req_valid = 4'b0010;
    send_check(1, 8'hC3, "wrap1", 1'b1);
    req_valid = 4'b1111; #1;
    chk("ptr2_all", 32'(req_ready), 32'h4);
    req_valid = 4'b1001; #1;
    chk("ptr2_wrap", 32'(req_ready), 32'h8);
    req_valid = '0;
    cyc();
    chk("peek_no_accept", 32'(busy), 32'd0);

    // Reset while data bit 3 is on the line
    req_data = 32'h0;
    req_valid = 4'b0001; #1;
    chk("mid_ready", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    wait_tick(); cyc(); cyc();
    chk("mid_start", 32'(tx), 32'd0);
    for (int b = 0; b < 4; b++) begin
      wait_tick(); cyc(); cyc();
    end
    chk("mid_bit3", 32'(tx), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    req_valid = 4'b0100;
    rst_n = 1'b0; #1;
    chk("async_tx", 32'(tx), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    chk("async_grant", 32'(grant_id), 32'd0);
    cyc(); rst_n = 1'b1; #1;
    req_valid = 4'b1101; #1;
    chk("ptr_cleared", 32'(req_ready), 32'h1);
    req_valid = 4'b0100;
    req_data = 32'h00_5A_00_00;
    send_check(2, 8'h5A, "fresh", 1'b1);

    // baud_tick tied high: one cycle per bit, tick on the accept edge ignored
    req_data = 32'hFF_00_00_00;
    req_valid = 4'b1000;
    tick_period = 1; baud_tick = 1'b1; #1;
    chk("fast_ready", 32'(req_ready), 32'h8);
    cyc(); req_valid = '0;
    chk("fast_busy", 32'(busy), 32'd1);
    chk("fast_tx0", 32'(tx), 32'd1);
    exp_tx = 11'b1_11111111_0_1;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      chk($sformatf("fast_tx%0d", k), 32'(tx), 32'(exp_tx[k-1]));
      if (k == 10) chk("fast_busy_stop", 32'(busy), 32'd1);
      if (k == 11) chk("fast_busy_done", 32'(busy), 32'd0);
    end

    // Two stop bits on the second build
    tick_period = 4;
    req_data2 = 32'h0;
    req_valid2 = 4'b0001; #1;
    chk("sb2_ready", 32'(req_ready2), 32'h1);
    cyc(); req_valid2 = '0;
    chk("sb2_busy", 32'(busy2), 32'd1);
    wait_tick(); cyc(); cyc();
    chk("sb2_start", 32'(tx2), 32'd0);
    for (int b = 0; b < 8; b++) begin
      wait_tick(); cyc(); cyc();
      rx[b] = tx2;
    end
    chk("sb2_byte", 32'(rx), 32'h0);
    wait_tick(); cyc(); cyc();
    chk("sb2_stop1", 32'(tx2), 32'd1);
    wait_tick(); cyc();
    chk("sb2_busy_after1", 32'(busy2), 32'd1);
    cyc();
    chk("sb2_stop2", 32'(tx2), 32'd1);
    wait_tick(); cyc();
    chk("sb2_done", 32'(busy2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmit line between NUM_REQ byte sources, using round-robin arbitration and a valid/ready handshake. It serialises each granted byte as an 8N1-style frame (start, DATA_W data bits LSB-first, STOP_BITS stop bits). Bit timing comes from the single-cycle baud_tick strobe of the existing baud generator. The block sits between the on-chip requesters (e.g. debug/log/status sources) and the UART TX pin.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, bits per character
STOP_BITS, 1, stop bit periods per frame (1 or 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
baud_tick  input  1  one-cycle strobe, once per bit period, from baud generator
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept; transfer when valid&ready same cycle
tx  output  1  serial line, idle high
busy  output  1  high whenever state != IDLE
grant_id  output  $clog2(NUM_REQ)  index of requester whose byte is in flight/last served

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all state cleared on assertion regardless of clk.
- Reset values: tx=1, busy=0, grant_id=0, req_ready=0, state=IDLE, rr pointer=0, bit counter=0, shift reg=0.
- States: IDLE, ALIGN, START, DATA, STOP.
- IDLE: req_ready combinational = one-hot of the first asserted req_valid searching from pointer upward with wrap (pointer, pointer+1, ... mod NUM_REQ); all zero if no valid or state!=IDLE. At most one ready bit high.
- Accept (IDLE, some valid): latch data into shift reg, grant_id<=i, pointer<=(i+1) mod NUM_REQ, go ALIGN. Requester must hold data stable only in accept cycle.
- ALIGN: tx=1; on baud_tick -> START (aligns start bit to full bit period; no partial first bit).
- START: tx=0; on baud_tick -> DATA, bit counter=0.
- DATA: tx=shift reg LSB; on baud_tick shift right, counter+1; after DATA_W-th tick -> STOP, counter=0.
- STOP: tx=1; on baud_tick counter+1; after STOP_BITS-th tick -> IDLE.
- tx is registered; it changes the cycle after the state transition that implies it. tx has no glitches; it stays constant between ticks.
- Frame length from first START cycle = (1+DATA_W+STOP_BITS) baud periods exactly.
- Back-to-back: IDLE is held a minimum of 1 cycle; the next accept may occur in the first IDLE cycle; then ALIGN waits for the next tick.
- baud_tick in the same cycle as accept is ignored (ALIGN starts next cycle).
- baud_tick high every cycle is legal: each bit lasts 1 cycle.
- req_valid deasserted before grant: no accept, no state change. Valid held by non-granted requesters persists; no starvation (max wait = NUM_REQ-1 frames).
- Reset mid-frame: tx returns high immediately (async), frame aborted, pointer=0; no partial byte is resumed.
- grant_id holds its value through IDLE until the next accept.

Test Plan:
- Single send: req_valid[1]=1, data=8'hA5, tick every 16 cycles -> ready[1] pulses 1 cycle; after align, tx = 0,1,0,1,0,0,1,0,1,1 each 16 cycles; busy falls after stop; grant_id=1.
- Round-robin: all 4 valid continuously with data 8'h10+i -> frames sent in order 0,1,2,3,0; each ready pulses once per frame; no requester served twice consecutively.
- Pointer wrap/skip: pointer=3, only req 1 valid -> req 1 granted, pointer becomes 2.
- Tick corner: baud_tick tied high, data 8'hFF -> frame 0,1×8,1 one cycle per bit; tick coincident with accept does not shorten ALIGN.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1, busy=0, req_ready=0 immediately; after release req 2 valid -> full fresh frame from start bit.
- STOP_BITS=2 build: data 8'h00 -> tx high for exactly 2 tick periods before busy drops.
